// File: rtl/conv_window_sched_pkg.sv
// Shared defaults, FSM state encoding and the saturating counter helper for conv_window_sched.
// SCHED_PERF_CNT_EN selects whether the performance counters are built.
package conv_window_sched_pkg;

    localparam int MAC_CN_HGT_DEF = 9;
    localparam int BB_WIDTH_DEF   = 40;
    localparam int FXP_DEF        = 8;
    localparam int N_C_DEF        = 32;
    localparam int ROW_CW_DEF     = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_FIRE = 3'd2,
        ST_WAIT = 3'd3,
        ST_LOAD = 3'd4,
        ST_DONE = 3'd5
    } sched_state_e;

`ifdef SCHED_PERF_CNT_EN
    localparam bit SCHED_PERF_CNT_ON = 1'b1;
`else
    localparam bit SCHED_PERF_CNT_ON = 1'b0;
`endif

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/conv_window_sched_row_line_buffer.sv
// MAC_CN_HGT-deep row shift register; row 0 is the oldest row and new rows enter at the top index.
module row_line_buffer #(
    parameter int ROWS  = 9,
    parameter int ROW_W = 320
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_en,
    input  logic [ROW_W-1:0]        row_in,
    output logic [ROWS*ROW_W-1:0]   bb_out
);

    logic [ROW_W-1:0] rows_q [ROWS];
    logic [ROW_W-1:0] rows_d [ROWS];

    always_comb begin
        rows_d = rows_q;
        if (load_en) begin
            for (int j = 0; j < ROWS - 1; j++) begin
                rows_d[j] = rows_q[j+1];
            end
            rows_d[ROWS-1] = row_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < ROWS; j++) begin
                rows_q[j] <= '0;
            end
        end else begin
            rows_q <= rows_d;
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_flat
        assign bb_out[g*ROW_W +: ROW_W] = rows_q[g];
    end

endmodule

// File: rtl/conv_window_sched.sv
// Sliding-window scheduler: fills the line buffer, fires the MAC macro per window and slides one row.
// Define SCHED_PERF_CNT_EN to build the stall/mac cycle counters; otherwise those ports read 0.
module conv_window_sched
    import conv_window_sched_pkg::*;
#(
    parameter int MAC_CN_HGT = MAC_CN_HGT_DEF,
    parameter int BB_WIDTH   = BB_WIDTH_DEF,
    parameter int FXP        = FXP_DEF,
    parameter int N_C        = N_C_DEF,
    parameter int ROW_CW     = ROW_CW_DEF
) (
    input  logic                                CLK,
    input  logic                                RSTn,
    input  logic                                start,
    input  logic [ROW_CW-1:0]                   cfg_rows,
    input  logic [BB_WIDTH*FXP-1:0]             row_in,
    input  logic                                row_valid,
    output logic                                row_ready,
    output logic [MAC_CN_HGT*BB_WIDTH*FXP-1:0]  BB_OUT,
    output logic                                mac_start,
    input  logic                                mac_done,
    output logic [ROW_CW-1:0]                   win_row,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    output logic [31:0]                         stall_cycles,
    output logic [31:0]                         mac_cycles
);

    localparam int               ROW_W = BB_WIDTH * FXP;
    localparam logic [ROW_CW-1:0] HGT_C = ROW_CW'(MAC_CN_HGT);
    localparam logic [ROW_CW-1:0] ONE_C = ROW_CW'(1);

    // A row must hold exactly one macro firing's worth of windows plus the kernel overhang.
    if (BB_WIDTH != N_C + MAC_CN_HGT - 1) begin : g_geom_chk
        $error("conv_window_sched: BB_WIDTH must equal N_C+MAC_CN_HGT-1");
    end

    sched_state_e        state_q, state_d;
    logic [ROW_CW-1:0]   cfg_rows_q, cfg_rows_d;
    logic [ROW_CW-1:0]   fill_cnt_q, fill_cnt_d;
    logic [ROW_CW-1:0]   rows_in_q, rows_in_d;
    logic [ROW_CW-1:0]   win_row_q, win_row_d;
    logic                err_q, err_d;
    logic                row_ready_q, row_ready_d;
    logic                mac_start_q, mac_start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept;
    logic                start_acc;

    // row_ready_q is high exactly in FILL/LOAD, so this is the handshake for both states.
    assign accept    = row_valid & row_ready_q;
    assign start_acc = (state_q == ST_IDLE) & start;

    always_comb begin
        state_d    = state_q;
        cfg_rows_d = cfg_rows_q;
        fill_cnt_d = fill_cnt_q;
        rows_in_d  = rows_in_q;
        win_row_d  = win_row_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_rows_d = cfg_rows;
                    fill_cnt_d = '0;
                    rows_in_d  = '0;
                    win_row_d  = '0;
                    err_d      = 1'b0;
                    if (cfg_rows < HGT_C) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (accept) begin
                    fill_cnt_d = fill_cnt_q + ONE_C;
                    rows_in_d  = rows_in_q + ONE_C;
                    if (fill_cnt_q == HGT_C - ONE_C) begin
                        state_d = ST_FIRE;
                    end
                end
            end
            ST_FIRE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mac_done) begin
                    win_row_d = win_row_q + ONE_C;
                    state_d   = (rows_in_q == cfg_rows_q) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    rows_in_d = rows_in_q + ONE_C;
                    state_d   = ST_FIRE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        row_ready_d = (state_d == ST_FILL) || (state_d == ST_LOAD);
        mac_start_d = (state_d == ST_FIRE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            cfg_rows_q  <= '0;
            fill_cnt_q  <= '0;
            rows_in_q   <= '0;
            win_row_q   <= '0;
            err_q       <= 1'b0;
            row_ready_q <= 1'b0;
            mac_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_rows_q  <= cfg_rows_d;
            fill_cnt_q  <= fill_cnt_d;
            rows_in_q   <= rows_in_d;
            win_row_q   <= win_row_d;
            err_q       <= err_d;
            row_ready_q <= row_ready_d;
            mac_start_q <= mac_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    row_line_buffer #(
        .ROWS  (MAC_CN_HGT),
        .ROW_W (ROW_W)
    ) u_line_buf (
        .clk     (CLK),
        .rst_n   (RSTn),
        .load_en (accept),
        .row_in  (row_in),
        .bb_out  (BB_OUT)
    );

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] mac_cycles_q, mac_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        mac_cycles_d   = mac_cycles_q;
        if (start_acc) begin
            stall_cycles_d = '0;
            mac_cycles_d   = '0;
        end else begin
            if (((state_q == ST_FILL) || (state_q == ST_LOAD)) && !row_valid) begin
                stall_cycles_d = sat_inc32(stall_cycles_q);
            end
            if (state_q == ST_WAIT) begin
                mac_cycles_d = sat_inc32(mac_cycles_q);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stall_cycles_q <= '0;
            mac_cycles_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            mac_cycles_q   <= mac_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign mac_cycles   = mac_cycles_q;
`else
    assign stall_cycles = 32'd0;
    assign mac_cycles   = 32'd0;
`endif

    assign row_ready = row_ready_q;
    assign mac_start = mac_start_q;
    assign win_row   = win_row_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_conv_window_sched.sv
// Scoreboard bench for conv_window_sched: expected firings/completions are queued at start and
// checked when mac_start/done appear; a responder returns mac_done 4 cycles after each firing.
module tb_conv_window_sched;
    import conv_window_sched_pkg::*;

    localparam int H     = 9;
    localparam int BBW   = 40;
    localparam int FX    = 8;
    localparam int NC    = 32;
    localparam int RCW   = 8;
    localparam int ROW_W = BBW * FX;
`ifdef SCHED_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [RCW-1:0]        cfg_rows;
    logic [ROW_W-1:0]      row_in;
    logic                  row_valid;
    logic                  row_ready;
    logic [H*ROW_W-1:0]    BB_OUT;
    logic                  mac_start;
    logic                  mac_done_w;
    logic                  resp_done;
    logic                  inj_done;
    logic [RCW-1:0]        win_row;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [31:0]           stall_cycles;
    logic [31:0]           mac_cycles;

    typedef struct { int win; int base; } fire_t;
    typedef struct { bit err; int win; } done_t;
    fire_t fire_q[$];
    done_t done_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int mdone_cyc = 0;
    int done_seen = 0;
    int resp_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mac_done_w = resp_done | inj_done;

    conv_window_sched #(
        .MAC_CN_HGT (H),
        .BB_WIDTH   (BBW),
        .FXP        (FX),
        .N_C        (NC),
        .ROW_CW     (RCW)
    ) dut (
        .CLK          (clk),
        .RSTn         (rst_n),
        .start        (start),
        .cfg_rows     (cfg_rows),
        .row_in       (row_in),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .BB_OUT       (BB_OUT),
        .mac_start    (mac_start),
        .mac_done     (mac_done_w),
        .win_row      (win_row),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .stall_cycles (stall_cycles),
        .mac_cycles   (mac_cycles)
    );

    task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [ROW_W-1:0] rep(input int v);
        logic [ROW_W-1:0] r;
        for (int p = 0; p < BBW; p++) r[p*FX +: FX] = FX'(v);
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input int j);
        return BB_OUT[j*ROW_W +: ROW_W];
    endfunction

    // Behavioural macro: completes 4 cycles after each firing, forgets everything on reset.
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (!rst_n) begin
                resp_cnt = 0;
            end else if (mac_start) begin
                resp_cnt = 4;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    resp_done = 1'b1;
                    mdone_cyc = cyc;
                end
            end
        end
    end

    // Monitor: every firing and every done pulse must match the next queued expectation.
    initial begin
        fire_t e;
        done_t d;
        forever begin
            @(negedge clk);
            if (rst_n && mac_start) begin
                if (fire_q.size() == 0) begin
                    chk("unexpected_fire", 1, 0);
                end else begin
                    e = fire_q.pop_front();
                    chk("fire_win_row", win_row, e.win);
                    chk("fire_busy", busy, 1);
                    for (int j = 0; j < H; j++) chk("fire_bb_row", row_of(j), rep(e.base + j));
                end
            end
            if (rst_n && done) begin
                done_seen++;
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    d = done_q.pop_front();
                    chk("done_err", err, d.err);
                    chk("done_win_row", win_row, d.win);
                    if (d.err) chk("err_done_lat", cyc - start_cyc, 1);
                    else       chk("done_lat", cyc - mdone_cyc, 1);
                end
            end
        end
    end

    task automatic start_img(input int rows, input int base);
        for (int k = 0; k <= rows - H; k++) fire_q.push_back('{win: k, base: base + k});
        done_q.push_back('{err: (rows < H), win: (rows < H) ? 0 : rows - H + 1});
        @(posedge clk); #1;
        start = 1'b1;
        cfg_rows = RCW'(rows);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int n, input bit tog);
        bit acc;
        int budget;
        for (int i = 0; i < n; i++) begin
            row_in = rep(first + i);
            row_valid = 1'b1;
            acc = 1'b0;
            budget = 0;
            while (!acc && budget < 60) begin
                @(negedge clk);
                acc = row_ready;
                @(posedge clk); #1;
                budget++;
            end
            if (!acc) chk("feed_timeout", 0, 1);
            if (tog && i < n - 1) begin
                row_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        row_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_seen < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("done_count", done_seen, target);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_row_ready"}, row_ready, 0);
        chk({tag, "_mac_start"}, mac_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_win_row"}, win_row, 0);
        chk({tag, "_stall"}, stall_cycles, 0);
        chk({tag, "_maccyc"}, mac_cycles, 0);
        for (int j = 0; j < H; j++) chk({tag, "_bb"}, row_of(j), 0);
    endtask

    initial begin
        bit rr_seen;
        rst_n = 1'b0;
        start = 1'b0;
        cfg_rows = '0;
        row_in = '0;
        row_valid = 1'b0;
        inj_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("rst");
        rst_n = 1'b1;

        // Single firing: window exactly fills, fire 1 cycle after 9th accept.
        start_img(9, 0);
        feed(0, 9, 0);
        @(negedge clk);
        chk("fire_latency", mac_start, 1);
        wait_done(1);

        // Four firings sliding down through 12 rows.
        start_img(12, 0);
        feed(0, 12, 0);
        wait_done(2);

        // Too few rows: error, immediate done, no row handshake.
        start_img(5, 0);
        rr_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            rr_seen |= row_ready;
        end
        chk("err_no_ready", rr_seen, 0);
        chk("err_sticky", err, 1);
        wait_done(3);

        // Gapped fill with spurious mac_done in FILL and in the FIRE cycle.
        start_img(9, 50);
        fork
            feed(50, 9, 1);
            begin
                repeat (3) @(posedge clk);
                #1 inj_done = 1'b1;
                @(posedge clk);
                #1 inj_done = 1'b0;
            end
        join
        @(negedge clk);
        chk("fire_cycle", mac_start, 1);
        chk("err_cleared", err, 0);
        chk("stall_at_fire", stall_cycles, (PERF != 0) ? 8 : 0);
        chk("maccyc_at_fire", mac_cycles, 0);
        inj_done = 1'b1;
        @(posedge clk);
        #1 inj_done = 1'b0;
        wait_done(4);
        chk("maccyc_final", mac_cycles, (PERF != 0) ? 4 : 0);

        // Asynchronous reset in the middle of the second WAIT, then a clean rerun.
        start_img(12, 0);
        feed(0, 10, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_quiet("midrst");
        fire_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        start_img(12, 30);
        feed(30, 12, 0);
        wait_done(5);

        chk("fire_q_empty", fire_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1, "global timeout");
    end

endmodule
